lcd_bus_driver: RTL
===================

# lcd_bus_driver

Physical-bus stage directly downstream of the display controller. It watches the controller's byte and register-select outputs, detects each new transfer, and drives an HD44780-style parallel LCD write cycle with correct setup, enable-pulse, hold and execution timing. When the init feature is compiled in, it also runs the LCD power-on initialisation sequence before accepting any transfers.

## Interface
- T_POWERUP, 750000: cycles waited after reset before the first init write (15 ms at 50 MHz).
- T_SETUP, 3: cycles from lcd_db/lcd_rs valid to lcd_e rising.
- T_PULSE, 12: cycles lcd_e is held high.
- T_HOLD, 2: cycles lcd_db/lcd_rs are held after lcd_e falls.
- T_EXEC, 2000: execution wait for normal writes (40 µs).
- T_CLEAR, 80000: execution wait for clear/home commands (1.6 ms).
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- data  input  8  byte from the display controller.
- rs  input  1  register select from the controller: 1 = data, 0 = command.
- rw  input  1  read/write from the controller; transfers are accepted only while rw = 0.
- lcd_db  output  8  LCD data bus.
- lcd_rs  output  1  LCD register select.
- lcd_rw  output  1  LCD R/W, constant 0 (write-only bus).
- lcd_e  output  1  LCD enable strobe.
- busy  output  1  high while a write cycle or init is in progress.
- init_done  output  1  high once initialisation has completed; stays high until rst.

## Operation
- States: POWERUP, INIT_LOAD, SETUP, PULSE, HOLD, EXEC, IDLE.
- Holds a 9-bit register last = {rs, data} of the last accepted transfer; its reset value is 9'h000.
- In IDLE, when {rs, data} != last and rw = 0, the block accepts the transfer:
  - Latches {rs, data} into last, lcd_rs and lcd_db.
  - Goes to SETUP.
- SETUP (T_SETUP cycles) -> PULSE (lcd_e = 1 for T_PULSE cycles) -> HOLD (T_HOLD cycles) -> EXEC -> IDLE.
- EXEC length:
  - T_CLEAR if lcd_rs = 0 and lcd_db is 0x01, 0x02 or 0x03.
  - T_EXEC otherwise.
- Input changes while busy are not queued. On return to IDLE, the current input is compared against last, so only the latest value is sent and intermediate values are lost.
- lcd_db and lcd_rs change only on the cycle a transfer is loaded. They are stable through SETUP, PULSE, HOLD and EXEC.
- A single down-counter, sized $clog2 of the largest parameter, is loaded on each state entry. The state advances when the counter reaches 0, so a state lasts exactly its parameter in cycles. Every parameter must be ≥ 1.
- busy = 1 in every state except IDLE.

## Timing
- Reset values: lcd_db = 0, lcd_rs = 0, lcd_rw = 0, lcd_e = 0, last = 0.
  - With LCD_INIT_EN: state POWERUP, busy = 1, init_done = 0.
  - Without LCD_INIT_EN: state IDLE, busy = 0, init_done = 1.
- Input differs in IDLE at cycle N:
  - lcd_db/lcd_rs/busy updated at N+1.
  - lcd_e rises at N+1+T_SETUP.
  - lcd_e falls at N+1+T_SETUP+T_PULSE.
  - busy falls at N+1+T_SETUP+T_PULSE+T_HOLD+Texec.
- Earliest next acceptance is the first IDLE cycle, with no extra gap cycle.
- rst mid-cycle: lcd_e drops to 0 on the next edge and all state returns to reset values. The init sequence restarts when it is compiled in.
- After reset the controller presents data = 0 and rs = 0, which matches last = 0, so no spurious transfer occurs.

## Configuration
- LCD_INIT_EN defined:
  - POWERUP waits T_POWERUP cycles.
  - INIT_LOAD then issues commands 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with rs = 0. Each runs the full SETUP/PULSE/HOLD/EXEC cycle, and 0x01 uses T_CLEAR.
  - After the last command: init_done = 1 and the block enters IDLE.
  - Controller input is ignored until then.
  - last is left at 0 after init.
- LCD_INIT_EN undefined: POWERUP and INIT_LOAD are absent, the block leaves reset in IDLE, and init_done is tied to 1.

## Test plan
Parameters for all scenarios: T_SETUP=2, T_PULSE=3, T_HOLD=1, T_EXEC=5, T_CLEAR=20, T_POWERUP=10.

1. Init run (LCD_INIT_EN): release rst -> lcd_e stays 0 for 10 cycles, then exactly six lcd_e pulses with lcd_db 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and lcd_rs = 0. The gap after 0x01 is 20 cycles. init_done rises after the sixth EXEC.
2. Data write (no init): rs = 1, data = 0x41 at cycle N -> lcd_db = 0x41, lcd_rs = 1 at N+1. lcd_e is high for cycles N+3..N+5. busy falls at N+12.
3. Clear command: rs = 0, data = 0x01 -> EXEC lasts 20 cycles. rs = 0, data = 0x80 -> EXEC lasts 5 cycles.
4. Changes while busy: during a 0x41 write, present 0x42 then 0x43 -> the next transfer is 0x43 only, loaded on the first IDLE cycle. 0x42 never appears on lcd_db.
5. No-change and rw gating: hold 0x41 after its write -> no second lcd_e pulse. Present 0x55 with rw = 1 -> no transfer.
6. Reset during PULSE: assert rst while lcd_e = 1 -> next edge shows lcd_e = 0, lcd_db = 0 and the reset values of busy/init_done.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// HD44780-style parallel write-cycle driver with setup/enable/hold/exec timing.
// Optional power-on init sequence compiled in with `define LCD_INIT_EN.
module lcd_bus_driver #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 3,
    parameter int T_PULSE   = 12,
    parameter int T_HOLD    = 2,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       rs,
    input  logic       rw,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       busy,
    output logic       init_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                max2(T_EXEC, T_CLEAR));
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    // Each state lasts its parameter in cycles: load N-1, leave when the count hits 0.
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);

    typedef enum logic [2:0] {
`ifdef LCD_INIT_EN
        S_POWERUP,
        S_INIT_LOAD,
`endif
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC,
        S_IDLE
    } state_t;

`ifdef LCD_INIT_EN
    localparam logic [CW-1:0] LD_POWERUP = CW'(T_POWERUP - 1);
    localparam state_t        ST_RESET   = S_POWERUP;
    localparam logic [CW-1:0] CNT_RESET  = LD_POWERUP;
    localparam logic          BUSY_RESET = 1'b1;
    localparam logic [2:0]    INIT_LEN   = 3'd6;
`else
    localparam state_t        ST_RESET   = S_IDLE;
    localparam logic [CW-1:0] CNT_RESET  = '0;
    localparam logic          BUSY_RESET = 1'b0;
`endif

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_ld;
    logic [8:0]      last;
    logic            accept;
    logic            exec_clear;

`ifdef LCD_INIT_EN
    logic [2:0]      init_idx;
    logic            init_load;
    logic            init_finish;
    logic            init_done_q;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            3'd5:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction
`endif

    assign lcd_rw     = 1'b0;
    assign exec_clear = !lcd_rs && (lcd_db == 8'h01 || lcd_db == 8'h02 || lcd_db == 8'h03);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
`ifdef LCD_INIT_EN
        init_load   = 1'b0;
        init_finish = 1'b0;
`endif
        case (state)
`ifdef LCD_INIT_EN
            S_POWERUP: begin
                if (cnt == '0) state_nxt = S_INIT_LOAD;
            end
            S_INIT_LOAD: begin
                init_load = 1'b1;
                state_nxt = S_SETUP;
            end
`endif
            S_SETUP: begin
                if (cnt == '0) state_nxt = S_PULSE;
            end
            S_PULSE: begin
                if (cnt == '0) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (cnt == '0) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (cnt == '0) begin
`ifdef LCD_INIT_EN
                    if (!init_done_q && init_idx != INIT_LEN) begin
                        state_nxt = S_INIT_LOAD;
                    end else begin
                        state_nxt   = S_IDLE;
                        init_finish = !init_done_q;
                    end
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
            S_IDLE: begin
                if (!rw && ({rs, data} != last)) begin
                    accept    = 1'b1;
                    state_nxt = S_SETUP;
                end
            end
            default: state_nxt = ST_RESET;
        endcase
    end

    // Counter reload value for whichever state is being entered.
    always_comb begin
        cnt_ld = '0;
        case (state_nxt)
            S_SETUP: cnt_ld = LD_SETUP;
            S_PULSE: cnt_ld = LD_PULSE;
            S_HOLD:  cnt_ld = LD_HOLD;
            S_EXEC:  cnt_ld = exec_clear ? LD_CLEAR : LD_EXEC;
            default: cnt_ld = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RESET;
            cnt    <= CNT_RESET;
            lcd_db <= 8'h00;
            lcd_rs <= 1'b0;
            lcd_e  <= 1'b0;
            busy   <= BUSY_RESET;
            last   <= 9'h000;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                cnt <= cnt_ld;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            lcd_e <= (state_nxt == S_PULSE);
            busy  <= (state_nxt != S_IDLE);
            if (accept) begin
                last   <= {rs, data};
                lcd_rs <= rs;
                lcd_db <= data;
            end
`ifdef LCD_INIT_EN
            else if (init_load) begin
                lcd_rs <= 1'b0;
                lcd_db <= init_cmd(init_idx);
            end
`endif
        end
    end

`ifdef LCD_INIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            init_idx    <= 3'd0;
            init_done_q <= 1'b0;
        end else begin
            if (init_load)   init_idx    <= init_idx + 3'd1;
            if (init_finish) init_done_q <= 1'b1;
        end
    end

    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif

endmodule
